pipeline_adder_arbiter: RTL and testbench

PIPELINE_ADDER_ARBITER -- requirements
Module: pipeline_adder_arbiter

---
 rtl/pa_arb_pkg.sv | 24 ++
 rtl/pa_rsp_fifo.sv | 76 +++++++
 rtl/pipeline_adder_arbiter.sv | 142 ++++++++++++++
 tb/tb_pipeline_adder_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_arb_pkg.sv
// Shared constants and types for the two-requester arbiter in front of the shared pipelined adder.
// Operand words are packed {a,b,c,d,e}, with a in the most significant field.
package pa_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int OP_W    = 5;
    localparam int NUM_OPS = 5;
    localparam int OPS_W   = NUM_OPS * OP_W;

    localparam int A_LSB = 4 * OP_W;
    localparam int B_LSB = 3 * OP_W;
    localparam int C_LSB = 2 * OP_W;
    localparam int D_LSB = 1 * OP_W;
    localparam int E_LSB = 0;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/pa_rsp_fifo.sv
// Per-requester result buffer. The head is presented combinationally and reads as zero while empty.
// A write and a pop in the same cycle keep the occupancy unchanged; a write into an empty buffer appears on the next cycle.
module pa_rsp_fifo
    import pa_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic            wr_en_i,
    input  logic [OP_W-1:0] wr_data_i,
    input  logic            rd_en_i,
    output logic [OP_W-1:0] rd_data_o,
    output logic            valid_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [OP_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_o   = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign do_rd     = rd_en_i && valid_o;
    assign do_wr     = wr_en_i && !full;
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_rd) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Upstream credit accounting must make a write into a full buffer impossible.
    assert property (@(posedge clk) disable iff (reset_i) wr_en_i |-> !full);

endmodule

// File: rtl/pipeline_adder_arbiter.sv
// Round-robin arbiter with credits that shares one external pipelined adder between two requesters.
// A tag pipeline travels alongside the adder and routes each add_s into the issuing requester's result buffer.
module pipeline_adder_arbiter
    import pa_arb_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OPS_W-1:0] req_ops,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [NUM_REQ*OP_W-1:0]  rsp_s,
    output logic [OPS_W-1:0]         add_ops,
    input  logic [OP_W-1:0]          add_s
);
    localparam int CRED_W = $clog2(DEPTH + 1);

    logic [OPS_W-1:0]   ops_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [OPS_W-1:0]   add_ops_q, add_ops_d;
    tag_t               op_tag_q, op_tag_d;
    tag_t               tag_q [LATENCY];
    logic [NUM_REQ-1:0] wr_en;

    // ptr_q names the requester that wins a tie. Grants are suppressed while reset is high.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = ptr_q;
        grant     = '0;
        ptr_d     = ptr_q;
        if (!reset) begin
            if (eligible[ptr_q]) begin
                grant_vld = 1'b1;
                grant_id  = ptr_q;
            end else if (eligible[~ptr_q]) begin
                grant_vld = 1'b1;
                grant_id  = ~ptr_q;
            end
        end
        if (grant_vld) begin
            grant[grant_id] = 1'b1;
            ptr_d           = ~grant_id;
        end
    end

    assign req_ready = grant;

    always_comb begin
        add_ops_d      = '0;
        op_tag_d       = TAG_IDLE;
        if (grant_vld) begin
            add_ops_d      = ops_arr[grant_id];
            op_tag_d.valid = 1'b1;
            op_tag_d.id    = grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            add_ops_q <= '0;
            op_tag_q  <= TAG_IDLE;
        end else begin
            ptr_q     <= ptr_d;
            add_ops_q <= add_ops_d;
            op_tag_q  <= op_tag_d;
        end
    end

    assign add_ops = add_ops_q;

    // op_tag_q travels with add_ops. The stages behind it delay the tag by the adder's latency,
    // so the last stage lines up with the add_s it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= TAG_IDLE;
            end
        end else begin
            tag_q[0] <= op_tag_q;
            for (int k = 1; k < LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [CRED_W-1:0] credit_q, credit_d;
            logic              pop;

            assign ops_arr[gi]  = req_ops[gi*OPS_W +: OPS_W];
            assign pop          = rsp_valid[gi] && rsp_ready[gi];
            assign eligible[gi] = req_valid[gi] && (credit_q < CRED_W'(DEPTH));
            assign wr_en[gi]    = tag_q[LATENCY-1].valid && (tag_q[LATENCY-1].id == ID_W'(gi));

            // The credit counts operations in flight plus results waiting in the buffer.
            always_comb begin
                credit_d = credit_q;
                if (grant[gi] && !pop) begin
                    credit_d = credit_q + 1'b1;
                end else if (!grant[gi] && pop) begin
                    credit_d = credit_q - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    credit_q <= '0;
                end else begin
                    credit_q <= credit_d;
                end
            end

            assert property (@(posedge clk) disable iff (reset) credit_q <= CRED_W'(DEPTH));

            pa_rsp_fifo #(
                .DEPTH (DEPTH)
            ) u_rsp_fifo (
                .clk       (clk),
                .reset_i   (reset),
                .wr_en_i   (wr_en[gi]),
                .wr_data_i (add_s),
                .rd_en_i   (rsp_ready[gi]),
                .rd_data_o (rsp_s[gi*OP_W +: OP_W]),
                .valid_o   (rsp_valid[gi])
            );
        end
    endgenerate

    assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// Scoreboard bench: the driver issues directed and random operations, and a negedge monitor
// queues the expected results on acceptance, then pops and compares them on every response handshake.
module tb_pipeline_adder_arbiter;
    localparam int LAT = 3;
    localparam int DEP = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [49:0] req_ops   = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [9:0]  rsp_s;
    logic [24:0] add_ops;
    logic [4:0]  add_s;

    logic [4:0]  exp_cur [2];
    logic [4:0]  exp_q0 [$];
    logic [4:0]  exp_q1 [$];
    int          grant_log [$];
    logic [24:0] exp_add = '0;
    bit          exp_add_vld = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipeline_adder_arbiter #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ops   (req_ops),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .add_ops   (add_ops),
        .add_s     (add_s)
    );

    function automatic logic [4:0] ref_add(input logic [24:0] o);
        logic [4:0] a, b, c, d, e;
        {a, b, c, d, e} = o;
        return ((a + b) - (c + d)) & e;
    endfunction

    function automatic logic [24:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {a[4:0], b[4:0], c[4:0], d[4:0], e[4:0]};
    endfunction

    // External adder: LAT register stages. It is never reset, so stale sums keep arriving after a reset.
    logic [4:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= ref_add(add_ops);
        for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign add_s = add_pipe[LAT-1];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end else begin
            $display("check %s ok value %0d", name, got);
        end
    endtask

    // Monitor: inputs change only just after posedge, so a negedge sample sees what the next edge will take.
    always @(negedge clk) begin
        logic [4:0] e;
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_add_vld = 1'b0;
        end else begin
            checks++;
            if (exp_add_vld && add_ops !== exp_add) begin
                errors++;
                $display("FAIL add_ops got %h expected %h", add_ops, exp_add);
            end
            checks++;
            if (req_ready[0] && req_ready[1]) begin
                errors++;
                $display("FAIL grant_onehot got req_ready=%b expected at most one bit", req_ready);
            end
            exp_add     = '0;
            exp_add_vld = 1'b1;
            if (req_valid[0] && req_ready[0]) begin
                exp_q0.push_back(exp_cur[0]);
                grant_log.push_back(0);
                exp_add = req_ops[24:0];
            end
            if (req_valid[1] && req_ready[1]) begin
                exp_q1.push_back(exp_cur[1]);
                grant_log.push_back(1);
                exp_add = req_ops[49:25];
            end
            if (rsp_valid[0] && rsp_ready[0]) begin
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL rsp0 got %0d expected no response", rsp_s[4:0]);
                end else begin
                    e = exp_q0.pop_front();
                    if (rsp_s[4:0] !== e) begin
                        errors++;
                        $display("FAIL rsp0 got %0d expected %0d", rsp_s[4:0], e);
                    end else $display("rsp0 ok value %0d", e);
                end
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL rsp1 got %0d expected no response", rsp_s[9:5]);
                end else begin
                    e = exp_q1.pop_front();
                    if (rsp_s[9:5] !== e) begin
                        errors++;
                        $display("FAIL rsp1 got %0d expected %0d", rsp_s[9:5], e);
                    end else $display("rsp1 ok value %0d", e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [24:0] ops, input logic [4:0] exp);
        if (i == 0) req_ops[24:0] = ops;
        else        req_ops[49:25] = ops;
        exp_cur[i]   = exp;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_accept(input int i, input int budget);
        int  n   = 0;
        bit  got = 1'b0;
        while (!got && n < budget) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) got = 1'b1;
            n++;
        end
        chk($sformatf("accept_req%0d", i), int'(got), 1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        reset = 1'b0;
        grant_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc, acc0, acc1;
        bit got;
        logic [1:0] acc;
        logic [24:0] ops;

        // Reset state, then a single request that was already pending before reset was released.
        set_req(0, pk(6, 7, 8, 3, 10), 5'd2);
        repeat (2) tick();
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_add_ops", int'(add_ops), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_s", int'(rsp_s), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("first_grant", int'(req_ready), 1);
        tick();
        req_valid[0] = 1'b0;
        chk("add_ops_load", int'(add_ops), int'(pk(6, 7, 8, 3, 10)));
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == LAT)     chk("lat_not_yet", int'(rsp_valid[0]), 0);
            if (k == LAT + 1) begin
                chk("lat_valid", int'(rsp_valid[0]), 1);
                chk("lat_value", int'(rsp_s[4:0]), 2);
            end
        end
        tick();
        rsp_ready = 2'b11;
        repeat (3) tick();

        // Wrap-around of the subtraction, issued from requester 1.
        set_req(1, pk(2, 8, 11, 13, 31), 5'd18);
        wait_accept(1, 10);
        repeat (LAT + 4) tick();

        // Both requesters valid: grants alternate, starting with requester 0 after reset.
        do_reset();
        rsp_ready = 2'b11;
        set_req(0, pk(4, 8, 7, 3, 1), 5'd0);
        set_req(1, pk(6, 10, 3, 3, 10), 5'd10);
        repeat (8) tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++)
            chk($sformatf("alt_grant%0d", k), (grant_log.size() > k) ? grant_log[k] : 99, k % 2);
        repeat (LAT + 6) tick();

        // Backpressure on requester 1 caps its accepted operations at DEP.
        do_reset();
        rsp_ready = 2'b01;
        set_req(0, pk(4, 8, 7, 3, 1), 5'd0);
        set_req(1, pk(6, 10, 3, 3, 10), 5'd10);
        acc0 = 0;
        acc1 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_valid[1] && req_ready[1]) acc1++;
            if (k >= 10 && req_valid[0] && req_ready[0]) acc0++;
        end
        chk("bp_accepts1", acc1, DEP);
        chk("bp_ready1_low", int'(req_ready[1]), 0);
        chk("bp_req0_served", int'(acc0 > 0), 1);
        tick();
        rsp_ready = 2'b11;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_valid[1] && req_ready[1]) got = 1'b1;
        end
        chk("bp_resume", int'(got), 1);
        tick();
        req_valid = '0;
        repeat (LAT + 8) tick();

        // Reset with three operations in flight: nothing may surface afterwards.
        do_reset();
        rsp_ready = 2'b11;
        set_req(0, pk(4, 8, 7, 3, 1), 5'd0);
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 20) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) n++;
            cyc++;
        end
        chk("inflight_accepts", n, 3);
        tick();
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", int'(rsp_valid), 0);
        end
        tick();
        set_req(0, pk(1, 9, 6, 3, 5), 5'd1);
        wait_accept(0, 10);
        repeat (LAT + 4) tick();

        // Random traffic and random response backpressure, checked against the reference adder.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    ops = pk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                             $urandom_range(0, 31), $urandom_range(0, 31));
                    if ($urandom_range(0, 3) != 0) set_req(i, ops, ref_add(ops));
                    else req_valid[i] = 1'b0;
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
        end

        // Drain everything; every expected result must have been delivered exactly once.
        tick();
        req_valid = '0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && rsp_valid == 2'b00) break;
        end
        chk("drain_q0_empty", exp_q0.size(), 0);
        chk("drain_q1_empty", exp_q1.size(), 0);
        chk("drain_rsp_idle", int'(rsp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
